// File: rtl/note_player.sv
// -----------------------------------------------------------------------------
// note_player
//   Playback datapath for the music device. Stores notes committed by the
//   sequencer into a small note memory and, during playback, renders the note
//   at the sequencer-supplied address as a square wave.
//
// Parameters
//   DEPTH      : note memory entries (note_counter is log2(DEPTH) bits wide)
//   TONE_SHIFT : right shift applied to every half-period constant
//                (0 for 50 MHz hardware, 10 for fast simulation)
//
// Ports
//   clk          in  : system clock
//   reset        in  : synchronous, active-high reset
//   ld_note      in  : level, high while the sequencer loads a note
//   note_in      in  : 3-bit note code (0 = rest, 1..7 = C4..B4)
//   ld_play      in  : level, high while in playback
//   note_counter in  : playback read address
//   audio_out    out : square-wave tone (registered)
//   cur_note     out : note currently sounding, 0 = rest (registered)
//   notes_stored out : number of valid entries, 0..DEPTH (registered)
//   full         out : high when notes_stored == DEPTH (registered)
// -----------------------------------------------------------------------------
module note_player #(
  parameter  int DEPTH      = 16,
  parameter  int TONE_SHIFT = 0,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_note,
  input  logic [2:0]    note_in,
  input  logic          ld_play,
  input  logic [AW-1:0] note_counter,
  output logic          audio_out,
  output logic [2:0]    cur_note,
  output logic [AW:0]   notes_stored,
  output logic          full
);

  localparam logic [AW:0] MAX_CNT = (AW+1)'(DEPTH);

  logic [2:0]  r_mem [DEPTH];
  logic [AW:0] r_stored;
  logic        r_full;
  logic        r_ld_note_q;
  logic [2:0]  r_cur_note;
  logic [16:0] r_tone_cnt;
  logic        r_audio;

  logic        w_wr_stb;
  logic        w_in_range;
  logic [2:0]  w_next_note;

  // Half-period in clock cycles for a note code. Rest maps to 1 so that the
  // reload value (HP - 1) is simply 0. Very large shifts clamp to 1.
  function automatic logic [16:0] hp(input logic [2:0] note);
    logic [16:0] base;
    logic [16:0] v;
    case (note)
      3'd1:    base = 17'd95556;  // C4
      3'd2:    base = 17'd85131;  // D4
      3'd3:    base = 17'd75843;  // E4
      3'd4:    base = 17'd71586;  // F4
      3'd5:    base = 17'd63776;  // G4
      3'd6:    base = 17'd56818;  // A4
      3'd7:    base = 17'd50619;  // B4
      default: base = 17'd1;
    endcase
    v = base >> TONE_SHIFT;
    if (v == 17'd0) v = 17'd1;
    return v;
  endfunction

  // One write per ld_note high period, regardless of how long it is held.
  assign w_wr_stb = ld_note & ~r_ld_note_q;

  // Entries at or beyond notes_stored have never been written since reset,
  // so they read as a rest. The read uses the registered memory, so a write
  // to the same address on this edge is only seen on the next cycle.
  assign w_in_range  = ({1'b0, note_counter} < r_stored);
  assign w_next_note = (ld_play && w_in_range) ? r_mem[note_counter] : 3'd0;

  // Note storage and fill count
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= 3'd0;
      r_stored    <= '0;
      r_full      <= 1'b0;
      r_ld_note_q <= 1'b0;
    end else begin
      r_ld_note_q <= ld_note;
      // Writes while full are dropped: no wrap, no overwrite.
      if (w_wr_stb && !r_full) begin
        r_mem[r_stored[AW-1:0]] <= note_in;
        r_stored                <= r_stored + 1'b1;
        r_full                  <= ((r_stored + 1'b1) == MAX_CNT);
      end
    end
  end

  // Tone generator: a note change restarts the phase with the output low;
  // an unchanged note keeps counting, so repeated notes are phase-continuous.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_note <= 3'd0;
      r_tone_cnt <= 17'd0;
      r_audio    <= 1'b0;
    end else if (w_next_note != r_cur_note) begin
      r_cur_note <= w_next_note;
      r_tone_cnt <= hp(w_next_note) - 17'd1;
      r_audio    <= 1'b0;
    end else if (r_cur_note == 3'd0) begin
      r_audio    <= 1'b0;
    end else if (r_tone_cnt == 17'd0) begin
      r_audio    <= ~r_audio;
      r_tone_cnt <= hp(r_cur_note) - 17'd1;
    end else begin
      r_tone_cnt <= r_tone_cnt - 17'd1;
    end
  end

  assign audio_out    = r_audio;
  assign cur_note     = r_cur_note;
  assign notes_stored = r_stored;
  assign full         = r_full;

endmodule

// File: tb/tb_note_player.sv
// -----------------------------------------------------------------------------
// tb_note_player
//   Directed bench for note_player with TONE_SHIFT = 10. Stimulus pushes the
//   expected output state for the current cycle into a queue; a monitor on the
//   falling edge pops and compares. A field of -1 means "don't care".
// -----------------------------------------------------------------------------
module tb_note_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       ld_note;
  logic [2:0] note_in;
  logic       ld_play;
  logic [3:0] note_counter;
  logic       audio_out;
  logic [2:0] cur_note;
  logic [4:0] notes_stored;
  logic       full;

  note_player #(.DEPTH(16), .TONE_SHIFT(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .ld_note      (ld_note),
    .note_in      (note_in),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .audio_out    (audio_out),
    .cur_note     (cur_note),
    .notes_stored (notes_stored),
    .full         (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    aud;
    int    cur;
    int    sto;
    int    ful;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic cmp(input string name, input string field, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s.%s actual=%0d required=%0d", name, field, act, req);
    end
  endtask

  // Monitor: every expectation queued since the last falling edge describes
  // the state after the most recent rising edge.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.aud >= 0) cmp(e.name, "audio_out",    int'(audio_out),    e.aud);
      if (e.cur >= 0) cmp(e.name, "cur_note",     int'(cur_note),     e.cur);
      if (e.sto >= 0) cmp(e.name, "notes_stored", int'(notes_stored), e.sto);
      if (e.ful >= 0) cmp(e.name, "full",         int'(full),         e.ful);
    end
  end

  task automatic expect_out(input string name, input int aud, input int cur,
                            input int sto, input int ful);
    exp_t e;
    e.name = name; e.aud = aud; e.cur = cur; e.sto = sto; e.ful = ful;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic store(input logic [2:0] n);
    note_in = n;
    ld_note = 1'b1;
    tick();
    ld_note = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; ld_note = 1'b0; note_in = 3'd0; ld_play = 1'b0; note_counter = 4'd0;

    // Reset and idle
    tick();
    expect_out("reset_hold", 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    tick();
    expect_out("idle", 0, 0, 0, 0);

    // One write per pulse: ld_note held 5 cycles
    note_in = 3'd6;
    ld_note = 1'b1;
    tick();
    expect_out("wr_first_edge", -1, -1, 1, 0);
    ticks(4);
    expect_out("wr_held", -1, -1, 1, 0);
    ld_note = 1'b0;
    tick();
    expect_out("wr_released", -1, -1, 1, 0);
    ld_play = 1'b1; note_counter = 4'd0;
    tick();
    expect_out("mem0_is_A", 0, 6, 1, -1);
    ld_play = 1'b0;
    tick();
    expect_out("play_off_rest", 0, 0, -1, -1);

    // Tone period, C: HP = 93
    do_reset();
    store(3'd1);
    expect_out("c_stored", -1, -1, 1, 0);
    ld_play = 1'b1; note_counter = 4'd0;
    tick();
    expect_out("c_start", 0, 1, -1, -1);
    ticks(92);
    expect_out("c_before_toggle1", 0, 1, -1, -1);
    tick();
    expect_out("c_toggle1", 1, 1, -1, -1);
    ticks(92);
    expect_out("c_before_toggle2", 1, 1, -1, -1);
    tick();
    expect_out("c_toggle2", 0, 1, -1, -1);
    ld_play = 1'b0;
    tick();
    expect_out("c_stop", 0, 0, -1, -1);

    // Full: 17 pulses, notes 1..7 cycling
    do_reset();
    for (int k = 0; k < 17; k++) begin
      store(3'((k % 7) + 1));
      if (k == 14) expect_out("fill_15", -1, -1, 15, 0);
      if (k == 15) expect_out("fill_16", -1, -1, 16, 1);
    end
    expect_out("fill_17_dropped", -1, -1, 16, 1);
    ld_play = 1'b1; note_counter = 4'd0;
    tick();
    expect_out("full_mem0_kept", 0, 1, -1, -1);
    note_counter = 4'd15;
    tick();
    expect_out("full_mem15", 0, 2, -1, -1);
    ld_play = 1'b0;
    tick();

    // Out-of-range read and stop
    do_reset();
    store(3'd5); store(3'd6); store(3'd7);
    expect_out("three_stored", -1, -1, 3, 0);
    ld_play = 1'b1; note_counter = 4'd5;
    tick();
    expect_out("oor_rest", 0, 0, -1, -1);
    ticks(3);
    expect_out("oor_rest_held", 0, 0, -1, -1);
    note_counter = 4'd2;
    tick();
    expect_out("b_start", 0, 7, -1, -1);
    ticks(48);
    expect_out("b_before_toggle", 0, 7, -1, -1);
    tick();
    expect_out("b_toggle", 1, 7, -1, -1);
    ld_play = 1'b0;
    tick();
    expect_out("b_stop", 0, 0, -1, -1);

    // Reset mid-tone while A (HP = 55) sounds
    ld_play = 1'b1; note_counter = 4'd1;
    tick();
    expect_out("a_start", 0, 6, -1, -1);
    ticks(55);
    expect_out("a_toggle", 1, 6, -1, -1);
    reset = 1'b1;
    tick();
    expect_out("reset_mid_tone", 0, 0, 0, 0);
    reset = 1'b0;
    note_counter = 4'd0;
    tick();
    expect_out("after_reset_rest", 0, 0, 0, 0);

    // Same-address read during write sees the pre-write contents
    note_in = 3'd4;
    ld_note = 1'b1;
    tick();
    expect_out("rw_same_edge", 0, 0, 1, 0);
    tick();
    expect_out("rw_next_cycle", 0, 4, 1, 0);
    ld_note = 1'b0; ld_play = 1'b0;
    ticks(2);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_player.md
# note_player

Playback datapath for the music device, at the far end of the note control sequencer. It stores the notes the sequencer commits (`ld_note`) into a 16-entry note memory. During playback it reads them back at the address the sequencer supplies (`ld_play`, `note_counter`) and renders each note as a square wave on `audio_out`. It owns note storage and tone generation; the sequencer owns only sequencing.

## Interface
Parameters:
- `DEPTH`, 16: note memory entries; `note_counter` width is log2(`DEPTH`).
- `TONE_SHIFT`, 0: right shift applied to every half-period constant. 0 for hardware at 50 MHz; 10 for simulation.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high reset.
- `ld_note` in 1: level from the sequencer, high while a note is being loaded.
- `note_in` in 3: note code to store. 0 = rest, 1..7 = C4 D4 E4 F4 G4 A4 B4.
- `ld_play` in 1: level from the sequencer, high while in playback.
- `note_counter` in 4: playback read address.
- `audio_out` out 1: square-wave tone.
- `cur_note` out 3: note currently sounding (0 = rest).
- `notes_stored` out 5: number of valid entries, 0..16.
- `full` out 1: high when `notes_stored` == 16.

## Operation
- **Reset.** While `reset` is high at a rising edge, all of these clear to 0 on that edge: every memory entry, `notes_stored`, the write pointer, the edge-detect flop, `cur_note`, the tone counter and `audio_out`. Reset mid-tone silences the output on that edge.
- **Write.**
  - `ld_note` is edge-detected: `wr_stb = ld_note & ~ld_note_q`. Exactly one write happens per `ld_note` high period, however long the level is held.
  - On `wr_stb` with `full` low: `mem[notes_stored[3:0]] <= note_in` and `notes_stored <= notes_stored + 1`.
  - On `wr_stb` with `full` high: the write is dropped. There is no wrap and no overwrite.
- **Read select.** Combinational `next_note` is:
  - `mem[note_counter]` when `ld_play` = 1 and `note_counter < notes_stored`;
  - 0 (rest) in every other case.
- **Simultaneous read/write, same address.** The read observes the pre-write contents. The new value is visible on the following cycle.
- **Tone generator.** One 17-bit down-counter `tone_cnt`. On each edge, evaluated in order:
  1. `next_note != cur_note`: `cur_note <= next_note`, `tone_cnt <= HP(next_note) - 1`, `audio_out <= 0`.
  2. Else if `cur_note == 0`: `audio_out` is held at 0 and `tone_cnt` is held.
  3. Else if `tone_cnt == 0`: toggle `audio_out` and reload `HP(cur_note) - 1`.
  4. Else: `tone_cnt <= tone_cnt - 1`.
- **Half-period constants.** `HP` is the base value shifted right by `TONE_SHIFT`. Base values:
  - C 95556, D 85131, E 75843, F 71586, G 63776, A 56818, B 50619.
  - With `TONE_SHIFT` = 10 these become 93, 83, 74, 69, 62, 55, 49.
  - An `HP` below 1 is clamped to 1.
- **Repeated note.** Consecutive identical notes do not restart the tone; the phase is continuous.

## Timing
- **Write.** `ld_note` rises, and at the next edge E the entry is written and `notes_stored` increments. Both are visible after E.
- **Note change.** An `ld_play`/`note_counter` change is sampled at edge E. `cur_note` updates at E and `audio_out` is 0 after E. The first toggle occurs at edge E + HP.
- **Tone.** The output period is 2·HP cycles with a 50 % duty cycle.
- **Leaving playback.** `ld_play` falling forces a rest at the next edge; `audio_out` is 0 after that edge.
- **Outputs.** All outputs are registered; none are combinational.

## Test plan
- **Reset and idle.** Assert `reset` 2 cycles, then release with `ld_play` = 0 -> `audio_out` = 0, `cur_note` = 0, `notes_stored` = 0, `full` = 0.
- **One write per pulse.** Hold `ld_note` high 5 cycles with `note_in` = 6 -> exactly one write; `notes_stored` = 1, `mem[0]` = 6.
- **Tone period** (`TONE_SHIFT` = 10). Store 1 (C), set `ld_play` = 1 and `note_counter` = 0 -> `cur_note` = 1; `audio_out` toggles every 93 cycles, first toggle 93 cycles after `cur_note` changes.
- **Full.** Issue 17 `ld_note` pulses with `note_in` = 1..7 cycling -> `notes_stored` = 16 and `full` = 1 after the 16th; the 17th changes nothing and `mem[0]` is unchanged.
- **Out-of-range and stop.** With 3 notes stored, `note_counter` = 5 and `ld_play` = 1 -> `cur_note` = 0 and `audio_out` = 0. Then `note_counter` = 2 -> the stored tone sounds; drop `ld_play` -> `audio_out` = 0 on the next edge.
- **Reset mid-tone.** Pulse `reset` for 1 cycle while A is sounding -> after that edge all outputs are 0 and `notes_stored` = 0; a subsequent playback of address 0 gives a rest.
